// File: rtl/btb_predictor.sv
// Direct-mapped BTB with 2-bit saturating direction counters; combinational lookup,
// registered training from the resolve stage, global freeze on rdy low.
module btb_predictor #(
   parameter int IDX_BITS = 6,
   parameter int ADDR_W   = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              rdy,
   input  logic [ADDR_W-1:0] lookup_pc,
   output logic              btb_hit,
   output logic [ADDR_W-1:0] btb_target,
   input  logic              upd_valid,
   input  logic [ADDR_W-1:0] upd_pc,
   input  logic [ADDR_W-1:0] upd_target,
   input  logic              upd_taken,
   input  logic              flush_all
);
   localparam int ENTRIES = 1 << IDX_BITS;
   localparam int TAG_W   = ADDR_W - IDX_BITS - 2;

   logic [ENTRIES-1:0] valid;
   logic [TAG_W-1:0]   tag_mem [ENTRIES];
   logic [ADDR_W-1:0]  tgt_mem [ENTRIES];
   logic [1:0]         ctr_mem [ENTRIES];

   logic [IDX_BITS-1:0] lk_idx;
   logic [TAG_W-1:0]    lk_tag;
   logic [IDX_BITS-1:0] up_idx;
   logic [TAG_W-1:0]    up_tag;
   logic                up_hit;
   logic                up_en;
   logic [1:0]          ctr_next;

   assign lk_idx = lookup_pc[IDX_BITS+1:2];
   assign lk_tag = lookup_pc[ADDR_W-1:IDX_BITS+2];
   assign up_idx = upd_pc[IDX_BITS+1:2];
   assign up_tag = upd_pc[ADDR_W-1:IDX_BITS+2];

   // Lookup reads the array before the clock edge, so a same-cycle update is not visible yet.
   always_comb begin
      btb_hit    = 1'b0;
      btb_target = '0;
      if (!rst && valid[lk_idx] && (tag_mem[lk_idx] == lk_tag) &&
          ctr_mem[lk_idx][1] && (lookup_pc[1:0] == 2'b00)) begin
         btb_hit    = 1'b1;
         btb_target = tgt_mem[lk_idx];
      end
   end

   assign up_hit = valid[up_idx] && (tag_mem[up_idx] == up_tag);
   assign up_en  = upd_valid && (upd_pc[1:0] == 2'b00);

   always_comb begin
      ctr_next = ctr_mem[up_idx];
      if (upd_taken) begin
         if (ctr_mem[up_idx] != 2'b11) ctr_next = ctr_mem[up_idx] + 2'b01;
      end else begin
         if (ctr_mem[up_idx] != 2'b00) ctr_next = ctr_mem[up_idx] - 2'b01;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         valid <= '0;
         for (int i = 0; i < ENTRIES; i++) begin
            tag_mem[i] <= '0;
            tgt_mem[i] <= '0;
            ctr_mem[i] <= 2'b01;
         end
      end else if (rdy) begin
         if (flush_all) begin
            valid <= '0;
         end else if (up_en) begin
            if (up_hit) begin
               ctr_mem[up_idx] <= ctr_next;
               if (upd_taken) tgt_mem[up_idx] <= upd_target;
            end else if (upd_taken) begin
               // Miss allocates over whatever lives at this index; no associativity.
               valid[up_idx]   <= 1'b1;
               tag_mem[up_idx] <= up_tag;
               tgt_mem[up_idx] <= upd_target;
               ctr_mem[up_idx] <= 2'b10;
            end
         end
      end
   end
endmodule

// File: tb/tb_btb_predictor.sv
// Directed bench for btb_predictor; expected lookups go through a scoreboard queue.
module tb_btb_predictor;
   logic        clk = 1'b0;
   logic        rst;
   logic        rdy;
   logic [31:0] lookup_pc;
   logic        btb_hit;
   logic [31:0] btb_target;
   logic        upd_valid;
   logic [31:0] upd_pc;
   logic [31:0] upd_target;
   logic        upd_taken;
   logic        flush_all;

   int checks = 0;
   int errors = 0;
   logic [32:0] exp_q [$];

   always #10 clk = ~clk;

   btb_predictor #(.IDX_BITS(6), .ADDR_W(32)) dut (
      .clk        (clk),
      .rst        (rst),
      .rdy        (rdy),
      .lookup_pc  (lookup_pc),
      .btb_hit    (btb_hit),
      .btb_target (btb_target),
      .upd_valid  (upd_valid),
      .upd_pc     (upd_pc),
      .upd_target (upd_target),
      .upd_taken  (upd_taken),
      .flush_all  (flush_all)
   );

   // Called just after a falling edge; each call consumes 1 time unit, well clear of the rising edge.
   task automatic chk(input string tag, input logic [31:0] pc, input logic eh, input logic [31:0] et);
      logic [32:0] e;
      lookup_pc = pc;
      exp_q.push_back({eh, et});
      #1;
      e = exp_q.pop_front();
      checks++;
      assert ({btb_hit, btb_target} === e)
      else begin
         errors++;
         $error("FAIL %s: got hit=%0b target=%h, expected hit=%0b target=%h",
                tag, btb_hit, btb_target, e[32], e[31:0]);
      end
   endtask

   task automatic upd(input logic [31:0] pc, input logic [31:0] tgt, input logic tk);
      upd_valid  = 1'b1;
      upd_pc     = pc;
      upd_target = tgt;
      upd_taken  = tk;
   endtask

   // Let one rising edge pass, then clear the one-shot controls.
   task automatic tick();
      @(negedge clk);
      upd_valid = 1'b0;
      flush_all = 1'b0;
   endtask

   initial begin
      rst = 1'b1; rdy = 1'b1; lookup_pc = '0;
      upd_valid = 1'b0; upd_pc = '0; upd_target = '0; upd_taken = 1'b0; flush_all = 1'b0;

      // Reset
      chk("reset_lookup", 32'h10, 1'b0, 32'h0);
      tick();
      rst = 1'b0;
      chk("post_reset", 32'h10, 1'b0, 32'h0);

      // First taken update allocates weakly-taken
      upd(32'h10, 32'h80, 1'b1);
      chk("same_cycle_alloc", 32'h10, 1'b0, 32'h0);
      tick();
      chk("alloc_hit", 32'h10, 1'b1, 32'h80);

      // Counter walks down then back up
      upd(32'h10, 32'h0, 1'b0);
      chk("rdw_old", 32'h10, 1'b1, 32'h80);
      tick();
      chk("ctr_01", 32'h10, 1'b0, 32'h0);
      upd(32'h10, 32'h0, 1'b0);
      tick();
      chk("ctr_00", 32'h10, 1'b0, 32'h0);
      upd(32'h10, 32'h0, 1'b0);
      tick();
      upd(32'h10, 32'h80, 1'b1);
      tick();
      chk("ctr_sat0_01", 32'h10, 1'b0, 32'h0);
      upd(32'h10, 32'h80, 1'b1);
      tick();
      chk("ctr_10", 32'h10, 1'b1, 32'h80);
      upd(32'h10, 32'h90, 1'b1);
      tick();
      chk("retarget", 32'h10, 1'b1, 32'h90);

      // Aliasing at index 4
      upd(32'h110, 32'h200, 1'b1);
      tick();
      chk("alias_evicted", 32'h10, 1'b0, 32'h0);
      chk("alias_new", 32'h110, 1'b1, 32'h200);

      // Misalignment, freeze, flush
      upd(32'h10, 32'h80, 1'b1);
      tick();
      chk("realloc", 32'h10, 1'b1, 32'h80);
      chk("misaligned_lookup", 32'h11, 1'b0, 32'h0);
      rdy = 1'b0;
      upd(32'h10, 32'h0, 1'b0);
      tick();
      upd(32'h10, 32'h0, 1'b0);
      flush_all = 1'b1;
      tick();
      rdy = 1'b1;
      chk("frozen", 32'h10, 1'b1, 32'h80);
      flush_all = 1'b1;
      upd(32'h110, 32'h200, 1'b1);
      tick();
      chk("flushed", 32'h10, 1'b0, 32'h0);
      chk("flush_drops_upd", 32'h110, 1'b0, 32'h0);

      // No allocation on not-taken miss; reset discards pending update
      upd(32'h24, 32'h400, 1'b0);
      tick();
      chk("nt_no_alloc", 32'h24, 1'b0, 32'h0);
      rst = 1'b1;
      upd(32'h24, 32'h400, 1'b1);
      chk("hit_masked_in_rst", 32'h10, 1'b0, 32'h0);
      tick();
      rst = 1'b0;
      chk("rst_drops_upd", 32'h24, 1'b0, 32'h0);
      upd(32'h24, 32'h400, 1'b1);
      tick();
      chk("alloc_24", 32'h24, 1'b1, 32'h400);
      upd(32'h26, 32'h500, 1'b1);
      tick();
      chk("misaligned_upd_ignored", 32'h24, 1'b1, 32'h400);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
